uart_tx_sequencer: RTL

Transmit-side controller for the UART baud clock generator. It accepts bytes from the level-reporting logic over a valid/ready handshake and enables the baud generator only while a frame is in flight. It counts 16x-oversampled baud ticks and serializes an 8N1 frame onto txd. It sits between the VU-meter sample formatter and the UART pin, and owns the generator's enable input.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_sequencer_if.sv | 13 +
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_tx_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit sequencer.
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Width of a counter that spans 0..oversample-1, never narrower than one bit.
  function automatic int tick_cnt_width(input int oversample);
    return (oversample > 1) ? $clog2(oversample) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// Byte handshake between the sample formatter (master) and the transmit sequencer (slave).
interface uart_tx_sequencer_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_bit_timer.sv
// Counts oversampled baud ticks and pulses bit_done on the last tick of each bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic clk_board,
  input  logic reset,
  input  logic tick_16x,
  input  logic run,
  output logic bit_done
);

  localparam int CNT_W = tick_cnt_width(OVERSAMPLE);

  logic [CNT_W-1:0] tick_cnt;
  logic             at_last;

  assign at_last  = (tick_cnt == CNT_W'(OVERSAMPLE - 1));
  assign bit_done = run && tick_16x && at_last;

  // Held at zero while idle so every frame starts from a full bit period.
  always_ff @(posedge clk_board or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (!run) begin
      tick_cnt <= '0;
    end else if (tick_16x) begin
      tick_cnt <= at_last ? '0 : tick_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART frame sequencer: accepts bytes, gates the baud generator and serializes start/data/stop.
// Define UART_PARITY_EN to insert a parity bit between the data and stop bits.
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic               clk_board,
  input  logic               reset,
  input  logic               tick_16x,
  output logic               gen_enable,
  output logic               txd,
  output logic               busy,
  uart_tx_sequencer_if.slave tx_bus
);

  localparam int BIT_CNT_W = $clog2(DATA_BITS + STOP_BITS + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  tx_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   txd_q, txd_d;
  logic                   run;
  logic                   bit_done;
  logic                   accept;

  assign accept          = tx_bus.tx_valid && (state_q == IDLE);
  assign run             = (state_q != IDLE);
  assign tx_bus.tx_ready = (state_q == IDLE);
  assign busy            = run;
  assign gen_enable      = run;
  assign txd             = txd_q;

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk_board (clk_board),
    .reset     (reset),
    .tick_16x  (tick_16x),
    .run       (run),
    .bit_done  (bit_done)
  );

`ifdef UART_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk_board or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= (^tx_bus.tx_data) ^ 1'(PARITY_ODD);
    end
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = 1'(PARITY_ODD);
`endif

  // txd is computed from the next state so the line flop changes together with the state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = tx_bus.tx_data;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef UART_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_PARITY_EN
      PARITY:  txd_d = parity_q;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_board or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
    end
  end

endmodule
